// File: rtl/temporizador_param.sv
// -----------------------------------------------------------------------------
// temporizador_param
//
// Board-level timebase and reset-stretch generator. The module divides
// clock_in into a 1 ms tick, a toggling half-period square wave and a heartbeat
// pulse. It also turns the raw reset button into a synchronised, stretched
// reset for downstream blocks.
//
// Parameters:
//   CLK_HZ    input clock frequency in Hz (multiple of 1 MHz)
//   TOGGLE_MS half-period of medio_sg in ms (>= 1)
//   BEAT_MS   width of latido in ms (1..TOGGLE_MS)
//   RST_US    rst_out stretch after button release in us (>= 1)
//   SEG_W     width of seg_cnt
//
// Ports:
//   clock_in   single clock
//   reset_n    synchronous active-low reset for every flop in the block
//   en         timebase run enable; low freezes the timebase
//   reset_btn  raw asynchronous push button, active-high
//   tick_ms    one-cycle pulse every 1 ms
//   medio_sg   toggles every TOGGLE_MS
//   latido     high for the first BEAT_MS of each medio_sg-high phase
//   rst_out    high while the button is held and for RST_US after release
//   seg_cnt    count of full medio_sg periods (only when
//              TEMPORIZADOR_SEG_CNT_EN is defined)
//
// Optional feature macro: TEMPORIZADOR_SEG_CNT_EN
// -----------------------------------------------------------------------------
module temporizador_param #(
  parameter int CLK_HZ    = 12_000_000,
  parameter int TOGGLE_MS = 500,
  parameter int BEAT_MS   = 100,
  parameter int RST_US    = 100,
  parameter int SEG_W     = 16
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             reset_btn,
  output logic             tick_ms,
  output logic             medio_sg,
  output logic             latido,
`ifdef TEMPORIZADOR_SEG_CNT_EN
  output logic             rst_out,
  output logic [SEG_W-1:0] seg_cnt
`else
  output logic             rst_out
`endif
);

  localparam int DIV     = CLK_HZ / 1000;
  localparam int RST_CYC = (CLK_HZ / 1_000_000) * RST_US;
  localparam int PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MS_W    = (TOGGLE_MS > 1) ? $clog2(TOGGLE_MS) : 1;
  localparam int STR_W   = $clog2(RST_CYC + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TOGGLE_MS - 1);
  localparam logic [MS_W:0]    BEAT_LIM = (MS_W + 1)'(BEAT_MS);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(RST_CYC);

  generate
    if (BEAT_MS > TOGGLE_MS) begin : g_bad_beat
      $error("temporizador_param: BEAT_MS must not exceed TOGGLE_MS");
    end
    if (CLK_HZ % 1_000_000 != 0) begin : g_bad_clk
      $error("temporizador_param: CLK_HZ must be a multiple of 1_000_000");
    end
    if (TOGGLE_MS < 1 || BEAT_MS < 1 || RST_US < 1 || SEG_W < 1) begin : g_bad_range
      $error("temporizador_param: TOGGLE_MS, BEAT_MS, RST_US and SEG_W must be >= 1");
    end
  endgenerate

  logic             btn_p0;
  logic             btn_s;
  logic [STR_W-1:0] str_cnt;
  logic [STR_W-1:0] str_nxt;
  logic             rst_nxt;

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_nxt;
  logic [MS_W-1:0]  ms_cnt;
  logic [MS_W-1:0]  ms_nxt;
  logic             med_nxt;
  logic             lat_nxt;
  logic             tick_nxt;
  logic             hold_tb;

  // Stretch counter: reload while the button is held, then count down.
  always_comb begin
    str_nxt = str_cnt;
    rst_nxt = 1'b0;
    if (btn_s) begin
      str_nxt = STR_LOAD;
      rst_nxt = 1'b1;
    end else if (str_cnt != '0) begin
      str_nxt = str_cnt - 1'b1;
      rst_nxt = (str_cnt != STR_W'(1));
    end
  end

  // Hold the timebase at zero on the edge rst_out rises and on every edge it
  // is still high, so counting resumes one cycle after rst_out falls.
  assign hold_tb = rst_out | rst_nxt;

  always_comb begin
    pre_nxt  = pre_cnt;
    ms_nxt   = ms_cnt;
    med_nxt  = medio_sg;
    tick_nxt = 1'b0;
    if (hold_tb) begin
      pre_nxt = '0;
      ms_nxt  = '0;
      med_nxt = 1'b0;
    end else if (en) begin
      if (pre_cnt == PRE_LAST) begin
        pre_nxt  = '0;
        tick_nxt = 1'b1;
        if (ms_cnt == MS_LAST) begin
          ms_nxt  = '0;
          med_nxt = ~medio_sg;
        end else begin
          ms_nxt = ms_cnt + 1'b1;
        end
      end else begin
        pre_nxt = pre_cnt + 1'b1;
      end
    end
  end

  // Built from next-state values so latido moves on the same edge as medio_sg.
  assign lat_nxt = med_nxt && ({1'b0, ms_nxt} < BEAT_LIM);

  // Stage p0: first synchroniser flop; stage p1: btn_s, rst_out and timebase.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      btn_p0   <= 1'b0;
      btn_s    <= 1'b0;
      str_cnt  <= '0;
      rst_out  <= 1'b0;
      pre_cnt  <= '0;
      ms_cnt   <= '0;
      medio_sg <= 1'b0;
      latido   <= 1'b0;
      tick_ms  <= 1'b0;
    end else begin
      btn_p0   <= reset_btn;
      btn_s    <= btn_p0;
      str_cnt  <= str_nxt;
      rst_out  <= rst_nxt;
      pre_cnt  <= pre_nxt;
      ms_cnt   <= ms_nxt;
      medio_sg <= med_nxt;
      latido   <= lat_nxt;
      tick_ms  <= tick_nxt;
    end
  end

`ifdef TEMPORIZADOR_SEG_CNT_EN
  logic seg_inc;

  // A natural high-to-low toggle closes one full period; a forced clear by
  // rst_out is not a completed period.
  assign seg_inc = !hold_tb && en && (pre_cnt == PRE_LAST) &&
                   (ms_cnt == MS_LAST) && medio_sg;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      seg_cnt <= '0;
    end else if (seg_inc) begin
      seg_cnt <= seg_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/temporizador_param.md
# temporizador_param

Parametrised timebase and reset-stretch generator for the board clock domain. It divides `clock_in` into a 1 ms tick, a programmable half-period toggle and a heartbeat pulse of programmable width. It also turns the raw reset button into a synchronised, stretched `rst_out`. It sits at the top level and feeds status LEDs and block-level resets, and it supersedes the fixed 12 MHz / 0.5 s timer.

## Interface
Parameters:
- `CLK_HZ`, 12_000_000, input clock frequency; must be a multiple of 1_000_000.
- `TOGGLE_MS`, 500, half-period of `medio_sg` in ms, ≥1.
- `BEAT_MS`, 100, width of `latido` in ms, 1..`TOGGLE_MS`.
- `RST_US`, 100, `rst_out` stretch after button release in µs, ≥1.
- `SEG_W`, 16, width of `seg_cnt` (used only with the macro).

Ports:
- `clock_in`, input, 1, single clock.
- `reset_n`, input, 1, synchronous, active-low reset.
- `en`, input, 1, timebase run enable; low freezes the timebase.
- `reset_btn`, input, 1, raw asynchronous button, active-high.
- `tick_ms`, output, 1, one-cycle pulse every 1 ms.
- `medio_sg`, output, 1, toggles every `TOGGLE_MS`.
- `latido`, output, 1, high for the first `BEAT_MS` of each `medio_sg`-high phase.
- `rst_out`, output, 1, high while the button is held and for `RST_US` after release.
- `seg_cnt`, output, `SEG_W`, elapsed full `medio_sg` periods (macro only).

## Operation
- Derived constants:
  - `DIV = CLK_HZ/1000`.
  - `RST_CYC = (CLK_HZ/1_000_000)*RST_US`.
  - Counter widths are `$clog2` of each terminal count.
- Elaboration-time check: fail with `$error` if `BEAT_MS > TOGGLE_MS` or if `CLK_HZ % 1_000_000 != 0`.
- Prescaler:
  - Counts 0..`DIV`-1 while `en`=1 and `rst_out`=0.
  - On wrap, `tick_ms` is registered high for one cycle.
- ms counter:
  - Counts 0..`TOGGLE_MS`-1 on `tick_ms`.
  - On wrap it returns to 0 and `medio_sg` inverts.
- `latido` is registered as `medio_sg && ms_cnt < BEAT_MS`, using next-state values so that it changes in the same cycle as `medio_sg`.
- Button path:
  - 2-FF synchroniser produces `btn_s`.
  - While `btn_s`=1, `rst_out`=1 and the stretch counter is loaded with `RST_CYC`.
  - While `btn_s`=0 and the counter is nonzero, the counter decrements; `rst_out` clears on the cycle the counter reaches 0.
  - A re-press during the stretch reloads the counter; `rst_out` stays high with no glitch.
- While `rst_out`=1:
  - Prescaler, ms counter, `medio_sg`, `latido` and `tick_ms` are forced to 0.
  - `seg_cnt` is not affected.
- `en`=0:
  - Prescaler and ms counter hold their values; `medio_sg` and `latido` hold; `tick_ms`=0.
  - The button path keeps running.
- `reset_n`=0, sampled on any edge (including mid-stretch or mid-period):
  - All outputs, counters and synchroniser flops go to 0 on that edge.
  - `rst_out`=0 even if the button is held; it re-asserts once `reset_n`=1 and the synchroniser passes the button level through.

## Timing
- Cycle 1 is the first rising edge sampling `reset_n`=1, with `en`=1 and the button idle.
- `tick_ms` is first high in cycle `DIV`, then every `DIV` cycles.
- `medio_sg` first rises in cycle `TOGGLE_MS*DIV`, then toggles every `TOGGLE_MS*DIV` cycles.
- `latido` rises in the same cycle as `medio_sg` and falls `BEAT_MS*DIV` cycles later. If `BEAT_MS == TOGGLE_MS`, `latido` equals `medio_sg`.
- `rst_out` rises 3 cycles after the `reset_btn` rising edge (2 sync + 1 register).
- `rst_out` falls `RST_CYC` cycles after `btn_s` falls, i.e. `RST_CYC`+2 cycles after the `reset_btn` falling edge.
- After `rst_out` falls, the timebase restarts as from cycle 1.
- `en` deassert/reassert resumes mid-count with no lost or extra ticks. The total active-`en` cycle count between ticks is `DIV`.

## Configuration
- `TEMPORIZADOR_SEG_CNT_EN` defined:
  - `seg_cnt` increments on each `medio_sg` falling transition (one full period).
  - It wraps modulo 2^`SEG_W` and is cleared only by `reset_n`.
- Not defined:
  - The `seg_cnt` port is absent and no counter logic is generated.

## Test plan
Bench parameters: `CLK_HZ`=2_000_000, `TOGGLE_MS`=5, `BEAT_MS`=2, `RST_US`=3. This gives `DIV`=2000 and `RST_CYC`=6.

- Release reset, `en`=1 → `tick_ms` pulses at cycles 2000, 4000, …; `medio_sg` rises at 10000 and falls at 20000; `latido` is high for cycles 10000..13999 only.
- `en`=0 for 500 cycles starting at cycle 1000 → first `tick_ms` moves to cycle 2500; `medio_sg`/`latido` are frozen during the gap.
- `reset_btn` high for 20 cycles at cycle 5000 → `rst_out` high from 5003 to 5028; timebase forced to 0, then `tick_ms` next at 5028+2000.
- Re-press 3 cycles into the stretch → `rst_out` stays continuously high and falls `RST_CYC`+2 cycles after the final release.
- `reset_n` low for 1 cycle mid-stretch and mid-`latido` → all outputs 0 on the next edge; the sequence restarts per the first scenario.
- With `TEMPORIZADOR_SEG_CNT_EN` and `SEG_W`=2 → `seg_cnt` reads 1, 2, 3, 0 at cycles 20000, 40000, 60000, 80000.
